// File: rtl/vote_pkg.sv
// vote_pkg: shared state encoding and counter width helper for the vote tally block
package vote_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VOTING = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/vote_popcount.sv
// vote_popcount: counts the set bits of an N-bit vector
module vote_popcount #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);
  // sum every bit; W is wide enough to hold N without wrap
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + W'(bits[i]);
  end
endmodule

// File: rtl/vote_tally_fsm.sv
// vote_tally_fsm: sequential majority-vote session controller; optional timeout via VOTE_TIMEOUT_EN
module vote_tally_fsm
  import vote_pkg::*;
#(
  parameter int N_VOTERS    = 5,
  parameter int THRESH      = 3,
  parameter int TIMEOUT_CYC = 1000,
  localparam int CNT_W      = cnt_width(N_VOTERS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                close,
  input  logic [N_VOTERS-1:0] vote_yes,
  input  logic [N_VOTERS-1:0] vote_no,
  output logic                voting,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    yes_cnt,
  output logic [CNT_W-1:0]    no_cnt,
  output logic [N_VOTERS-1:0] voted_mask,
  output logic                timed_out
);
  state_t state, state_n;
  logic [N_VOTERS-1:0] new_yes, new_no;
  logic [CNT_W-1:0] yes_add, no_add, yes_next, no_next;
  logic decided, timeout;
  assign new_yes  = vote_yes & ~vote_no & ~voted_mask;
  assign new_no   = vote_no & ~vote_yes & ~voted_mask;
  vote_popcount #(.N(N_VOTERS), .W(CNT_W)) u_pc_yes (.bits(new_yes), .count(yes_add));
  vote_popcount #(.N(N_VOTERS), .W(CNT_W)) u_pc_no  (.bits(new_no),  .count(no_add));
  assign yes_next = yes_cnt + yes_add;
  assign no_next  = no_cnt + no_add;
  assign decided  = (yes_next >= CNT_W'(THRESH)) || (no_next > CNT_W'(N_VOTERS - THRESH)) ||
                    (&(voted_mask | new_yes | new_no)) || close;
  assign voting   = state == ST_VOTING;
  assign done     = state == ST_DONE;
  assign pass     = done && (yes_cnt >= CNT_W'(THRESH));
  // state register
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_n;
  // next state: start opens a session from idle/done, any end condition closes it
  always_comb begin
    state_n = voting ? ((decided || timeout) ? ST_DONE : ST_VOTING)
            : start  ? ST_VOTING
            : done   ? ST_DONE : ST_IDLE;
  end
  // counts and mask: cleared on session entry, accumulated while voting, held otherwise
  always_ff @(posedge clk) begin
    if (rst || (!voting && start)) begin
      yes_cnt    <= '0;
      no_cnt     <= '0;
      voted_mask <= '0;
    end else if (voting) begin
      yes_cnt    <= yes_next;
      no_cnt     <= no_next;
      voted_mask <= voted_mask | new_yes | new_no;
    end
  end
`ifdef VOTE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer;
  assign timeout = voting && (timer == TMR_W'(TIMEOUT_CYC - 1));
  // session timer; a decision on the same edge wins over the timeout flag
  always_ff @(posedge clk) begin
    if (rst || (!voting && start)) begin
      timer     <= '0;
      timed_out <= 1'b0;
    end else if (voting) begin
      timer     <= timer + TMR_W'(1);
      timed_out <= timeout && !decided;
    end
  end
`else
  assign timeout   = 1'b0;
  assign timed_out = 1'b0;
`endif
endmodule
